// File: rtl/binary_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Optional leading-zero blanking is built when the macro BCD_BLANK_EN is defined.
module binary_to_bcd_seq #(
    parameter int BIN_W  = 36,
    parameter int DIGITS = 11
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  enable,
    input  logic                  start,
    input  logic [BIN_W-1:0]      data,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [BIN_W-1:0]   bin_r;
    logic [BCD_W-1:0]   work_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_scr_r;
    logic               done_r;
    logic [BCD_W-1:0]   bcd_r;
    logic               ovf_r;
    logic [BCD_W-1:0]   adj_s;
    logic [BCD_W+BIN_W-1:0] shifted_s;
    logic               busy_s;

    // Add 3 to every digit that is 5 or more, all digits in parallel.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] w);
        logic [BCD_W-1:0] r;
        r = w;
        for (int i = 0; i < DIGITS; i++) begin
            if (w[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = w[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = w[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Adjusted working digits concatenated with the binary register, shifted by one.
    always_comb begin
        adj_s     = dd_adjust(work_r);
        shifted_s = {adj_s[BCD_W-2:0], bin_r, 1'b0};
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
        end else if (enable) begin
            state_r <= state_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Next-state logic; a start seen in DONE chains straight into the next conversion.
    always_comb begin
        state_s = state_r;
        if (enable) begin
            case (state_r)
                ST_IDLE:  state_s = start ? ST_SHIFT : ST_IDLE;
                ST_SHIFT: state_s = (cnt_r == {CNT_W{1'b0}}) ? ST_DONE : ST_SHIFT;
                ST_DONE:  state_s = start ? ST_SHIFT : ST_IDLE;
                default:  state_s = ST_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Output decode.
    always_comb begin
        if (state_r == ST_SHIFT) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    // Datapath: operand capture, shifting, overflow scratch and result publish.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bin_r     <= {BIN_W{1'b0}};
            work_r    <= {BCD_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ovf_scr_r <= 1'b0;
            done_r    <= 1'b0;
            bcd_r     <= {BCD_W{1'b0}};
            ovf_r     <= 1'b0;
        end else if (enable) begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        bin_r     <= data;
                        work_r    <= {BCD_W{1'b0}};
                        ovf_scr_r <= 1'b0;
                        cnt_r     <= CNT_W'(BIN_W - 1);
                    end
                end
                ST_SHIFT: begin
                    done_r              <= 1'b0;
                    {work_r, bin_r}     <= shifted_s;
                    ovf_scr_r           <= ovf_scr_r | adj_s[BCD_W-1];
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    bcd_r  <= work_r;
                    ovf_r  <= ovf_scr_r;
                    done_r <= 1'b1;
                    if (start) begin
                        bin_r     <= data;
                        work_r    <= {BCD_W{1'b0}};
                        ovf_scr_r <= 1'b0;
                        cnt_r     <= CNT_W'(BIN_W - 1);
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_r;

    // Digit i blanks when it and every higher digit are zero; digit 0 always shows.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] w, input logic of);
        logic [DIGITS-1:0] m;
        logic              zero_above;
        m          = {DIGITS{1'b0}};
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (w[4*i +: 4] == 4'd0);
            m[i]       = zero_above & ~of;
        end
        return m;
    endfunction

    // Blank mask register, published together with bcd.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blank_r <= {DIGITS{1'b0}};
        end else if (enable && (state_r == ST_DONE)) begin
            blank_r <= blank_mask(work_r, ovf_scr_r);
        end else begin
            blank_r <= blank_r;
        end
    end

    assign blank = blank_r;
`else
    assign blank = {DIGITS{1'b0}};
`endif

    assign busy = busy_s;
    assign done = done_r;
    assign bcd  = bcd_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench for binary_to_bcd_seq: default 36-bit/11-digit instance plus an
// 8-bit/2-digit instance for overflow; blank expectations follow BCD_BLANK_EN.
module tb_binary_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en36, st36, busy36, done36, ovf36;
    logic [35:0] d36;
    logic [43:0] bcd36;
    logic [10:0] blank36;
    logic        en8, st8, busy8, done8, ovf8;
    logic [7:0]  d8, bcd8;
    logic [1:0]  blank8;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [35:0] data;
        logic [43:0] bcd;
        logic        ovf;
        logic [10:0] blank;
    } vec36_t;

    typedef struct {
        logic [7:0] data;
        logic [7:0] bcd;
        logic       ovf;
        logic [1:0] blank;
    } vec8_t;

    vec36_t v36[8];
    vec8_t  v8[5];

    always #5 clk = ~clk;

    binary_to_bcd_seq dut36 (
        .Clk(clk), .Reset_n(rst_n), .enable(en36), .start(st36), .data(d36),
        .busy(busy36), .done(done36), .bcd(bcd36), .ovf(ovf36), .blank(blank36)
    );

    binary_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut8 (
        .Clk(clk), .Reset_n(rst_n), .enable(en8), .start(st8), .data(d8),
        .busy(busy8), .done(done8), .bcd(bcd8), .ovf(ovf8), .blank(blank8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] eb36(input logic [10:0] b);
`ifdef BCD_BLANK_EN
        return b;
`else
        return 11'd0 & b;
`endif
    endfunction

    function automatic logic [1:0] eb8(input logic [1:0] b);
`ifdef BCD_BLANK_EN
        return b;
`else
        return 2'd0 & b;
`endif
    endfunction

    task automatic conv36(input vec36_t v, input string nm);
        int cyc;
        @(negedge clk);
        st36 = 1'b1;
        d36  = v.data;
        @(posedge clk);
        @(negedge clk);
        st36 = 1'b0;
        d36  = ~v.data;
        chk({nm, "_busy"}, 64'(busy36), 64'd1);
        cyc = 0;
        while (!done36 && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk({nm, "_lat"}, 64'(cyc), 64'd37);
        chk({nm, "_bcd"}, 64'(bcd36), 64'(v.bcd));
        chk({nm, "_ovf"}, 64'(ovf36), 64'(v.ovf));
        chk({nm, "_blank"}, 64'(blank36), 64'(eb36(v.blank)));
    endtask

    task automatic conv8(input vec8_t v, input string nm);
        int cyc;
        @(negedge clk);
        st8 = 1'b1;
        d8  = v.data;
        @(posedge clk);
        @(negedge clk);
        st8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk({nm, "_lat"}, 64'(cyc), 64'd9);
        chk({nm, "_bcd"}, 64'(bcd8), 64'(v.bcd));
        chk({nm, "_ovf"}, 64'(ovf8), 64'(v.ovf));
        chk({nm, "_blank"}, 64'(blank8), 64'(eb8(v.blank)));
    endtask

    initial begin
        int cyc;
        int cyc1;
        v36[0] = '{36'hFFFFFFFFF, 44'h68719476735, 1'b0, 11'b00000000000};
        v36[1] = '{36'd0,          44'h0,           1'b0, 11'b11111111110};
        v36[2] = '{36'd12345,      44'h12345,       1'b0, 11'b11111100000};
        v36[3] = '{36'd1000000,    44'h1000000,     1'b0, 11'b11110000000};
        v36[4] = '{36'd9,          44'h9,           1'b0, 11'b11111111110};
        v36[5] = '{36'd10,         44'h10,          1'b0, 11'b11111111100};
        v36[6] = '{36'd9999999999, 44'h09999999999, 1'b0, 11'b10000000000};
        v36[7] = '{36'd4294967296, 44'h04294967296, 1'b0, 11'b10000000000};
        v8[0]  = '{8'd99,  8'h99, 1'b0, 2'b00};
        v8[1]  = '{8'd5,   8'h05, 1'b0, 2'b10};
        v8[2]  = '{8'd0,   8'h00, 1'b0, 2'b10};
        v8[3]  = '{8'd100, 8'h00, 1'b1, 2'b00};
        v8[4]  = '{8'd255, 8'h55, 1'b1, 2'b00};

        rst_n = 1'b0;
        en36 = 1'b1; st36 = 1'b0; d36 = 36'd0;
        en8  = 1'b1; st8  = 1'b0; d8  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy36), 64'd0);
        chk("rst_done", 64'(done36), 64'd0);
        chk("rst_bcd", 64'(bcd36), 64'd0);
        chk("rst_ovf", 64'(ovf36), 64'd0);
        chk("rst_blank", 64'(blank36), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) conv36(v36[i], $sformatf("v36_%0d", i));
        for (int i = 0; i < 5; i++) conv8(v8[i], $sformatf("v8_%0d", i));

        // Stall 5 cycles mid-shift, stray start and data churn while busy.
        @(negedge clk);
        st36 = 1'b1;
        d36  = 36'd12345;
        @(posedge clk);
        @(negedge clk);
        st36 = 1'b0;
        cyc  = 0;
        while (!done36 && cyc < 200) begin
            en36 = !(cyc >= 10 && cyc < 15);
            st36 = (cyc == 20);
            d36  = 36'(cyc * 7);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        en36 = 1'b1;
        st36 = 1'b0;
        chk("stall_lat", 64'(cyc), 64'd42);
        chk("stall_bcd", 64'(bcd36), 64'h12345);
        en36 = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("done_hold", 64'(done36), 64'd1);
        en36 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("done_fall", 64'(done36), 64'd0);

        // Back-to-back: start held through DONE, second operand presented in DONE.
        st36 = 1'b1;
        d36  = 36'hFFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        cyc = 0;
        while (!done36 && cyc < 200) begin
            if (cyc >= 36) d36 = 36'd12345;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        st36 = 1'b0;
        cyc1 = cyc;
        chk("b2b_lat1", 64'(cyc1), 64'd37);
        chk("b2b_bcd1", 64'(bcd36), 64'h68719476735);
        chk("b2b_busy", 64'(busy36), 64'd1);
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!done36 && cyc < 300);
        chk("b2b_gap", 64'(cyc - cyc1), 64'd37);
        chk("b2b_bcd2", 64'(bcd36), 64'h12345);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        st36 = 1'b1;
        d36  = 36'd777;
        @(posedge clk);
        @(negedge clk);
        st36 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(busy36), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy36), 64'd0);
        chk("arst_done", 64'(done36), 64'd0);
        chk("arst_bcd", 64'(bcd36), 64'd0);
        chk("arst_ovf8", 64'(ovf8), 64'd0);
        chk("arst_bcd8", 64'(bcd8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        conv36(v36[6], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
